operation_sequencer: RTL and testbench

OPERATION_SEQUENCER -- requirements
Module: operation_sequencer

---
 rtl/operation_sequencer_if.sv | 30 +++
 rtl/operation_sequencer.sv | 101 ++++++++++
 tb/tb_operation_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/operation_sequencer_if.sv
// Handshake bundle between the micro-op sequencer, the instruction decoder and the
// executing unit.
interface operation_sequencer_if #(
  parameter int unsigned operation_code_length = 4
) ();

  logic                             start;
  logic [operation_code_length-1:0] oper_code_1;
  logic [operation_code_length-1:0] oper_code_2;
  logic [operation_code_length-1:0] oper_code_3;
  logic [operation_code_length-1:0] oper_code_4;
  logic                             op_ready;
  logic [operation_code_length-1:0] cur_oper;
  logic                             oper_valid;
  logic [1:0]                       slot;
  logic                             ir_load;
  logic                             busy;
  logic                             halted;

  modport master (
    input  start, oper_code_1, oper_code_2, oper_code_3, oper_code_4, op_ready,
    output cur_oper, oper_valid, slot, ir_load, busy, halted
  );

  modport slave (
    output start, oper_code_1, oper_code_2, oper_code_3, oper_code_4, op_ready,
    input  cur_oper, oper_valid, slot, ir_load, busy, halted
  );

endinterface

// File: rtl/operation_sequencer.sv
// Steps through the four decoded micro-op slots of the current instruction, issuing one
// op per accepted handshake and fetching the next instruction when the slots run out.
module operation_sequencer #(
  parameter int unsigned                   operation_code_length = 4,
  parameter logic [operation_code_length-1:0] oper_read_inst     = operation_code_length'(1),
  parameter logic [operation_code_length-1:0] oper_halt          = operation_code_length'(15)
) (
  input logic                    clk_i,
  input logic                    rst_i,
  operation_sequencer_if.master  bus
);

  localparam int unsigned W = operation_code_length;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StLatch = 2'd1;
  localparam logic [1:0] StIssue = 2'd2;
  localparam logic [1:0] StHalt  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [1:0]        slot_q, slot_d;
  logic              boot_q, boot_d;
  logic              fetch_q, fetch_d;
  logic [3:0][W-1:0] snap_q, snap_d;

  logic              fetch_sel;
  logic [W-1:0]      code_sel;
  logic              halt_hit;
  logic              oper_valid;
  logic              xfer;

  // Boot and forced-fetch both override the snapshot with an instruction read.
  assign fetch_sel  = boot_q | fetch_q;
  assign code_sel   = fetch_sel ? oper_read_inst : snap_q[slot_q];
  assign halt_hit   = (state_q == StIssue) && !fetch_sel && (code_sel == oper_halt);
  assign oper_valid = (state_q == StIssue) && !halt_hit;
  assign xfer       = oper_valid & bus.op_ready;

  assign bus.cur_oper   = (state_q == StIssue) ? code_sel : '0;
  assign bus.oper_valid = oper_valid;
  assign bus.slot       = slot_q;
  assign bus.ir_load    = xfer && (code_sel == oper_read_inst);
  assign bus.busy       = (state_q == StLatch) || (state_q == StIssue);
  assign bus.halted     = (state_q == StHalt);

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    boot_d  = boot_q;
    fetch_d = fetch_q;
    snap_d  = snap_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StIssue;
          boot_d  = 1'b1;
          slot_d  = 2'd0;
        end
      end
      StLatch: begin
        snap_d  = {bus.oper_code_4, bus.oper_code_3, bus.oper_code_2, bus.oper_code_1};
        slot_d  = 2'd0;
        boot_d  = 1'b0;
        state_d = StIssue;
      end
      StIssue: begin
        if (halt_hit) begin
          state_d = StHalt;
        end else if (xfer) begin
          if (code_sel == oper_read_inst) begin
            state_d = StLatch;
            fetch_d = 1'b0;
          end else if (slot_q == 2'd3) begin
            // Slots exhausted without a read: insert one, keeping SLOT at 3.
            fetch_d = 1'b1;
          end else begin
            slot_d = slot_q + 2'd1;
          end
        end
      end
      default: ; // StHalt is sticky until reset
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      slot_q  <= 2'd0;
      boot_q  <= 1'b0;
      fetch_q <= 1'b0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      boot_q  <= boot_d;
      fetch_q <= fetch_d;
      snap_q  <= snap_d;
    end
  end

endmodule

// File: tb/tb_operation_sequencer.sv
// Directed, table-driven check of the micro-op sequencer: boot, full instruction,
// stall, forced fetch, halt and mid-issue reset.
module tb_operation_sequencer;

  localparam int unsigned W = 4;
  localparam logic [W-1:0] RI  = 4'h1;  // read instruction
  localparam logic [W-1:0] RR  = 4'h2;  // read regs
  localparam logic [W-1:0] ALU = 4'h3;  // enable ALU and run
  localparam logic [W-1:0] WR  = 4'h4;  // write reg
  localparam logic [W-1:0] NOP = 4'h5;
  localparam logic [W-1:0] HLT = 4'hF;

  typedef struct {
    logic         rst;
    logic         start;
    logic         rdy;
    logic [W-1:0] c1, c2, c3, c4;
    logic         chk;
    logic [W-1:0] e_cur;
    logic         e_valid;
    logic [1:0]   e_slot;
    logic         e_irl;
    logic         e_busy;
    logic         e_halt;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  operation_sequencer_if #(.operation_code_length(W)) bus ();

  operation_sequencer #(
    .operation_code_length(W),
    .oper_read_inst       (RI),
    .oper_halt            (HLT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(input logic r, input logic s, input logic y,
                             input logic [W-1:0] c1, input logic [W-1:0] c2,
                             input logic [W-1:0] c3, input logic [W-1:0] c4,
                             input logic k, input logic [W-1:0] cur, input logic vl,
                             input logic [1:0] sl, input logic irl, input logic bsy,
                             input logic hlt);
    vec_t t;
    t.rst = r; t.start = s; t.rdy = y;
    t.c1 = c1; t.c2 = c2; t.c3 = c3; t.c4 = c4;
    t.chk = k; t.e_cur = cur; t.e_valid = vl; t.e_slot = sl;
    t.e_irl = irl; t.e_busy = bsy; t.e_halt = hlt;
    return t;
  endfunction

  task automatic apply(input vec_t t, input string tag, input int idx);
    logic [9:0] act, exp;
    rst             = t.rst;
    bus.start       = t.start;
    bus.op_ready    = t.rdy;
    bus.oper_code_1 = t.c1;
    bus.oper_code_2 = t.c2;
    bus.oper_code_3 = t.c3;
    bus.oper_code_4 = t.c4;
    @(negedge clk);
    if (t.chk) begin
      checks++;
      act = {bus.cur_oper, bus.oper_valid, bus.slot, bus.ir_load, bus.busy, bus.halted};
      exp = {t.e_cur, t.e_valid, t.e_slot, t.e_irl, t.e_busy, t.e_halt};
      if (act !== exp) begin
        errors++;
        $display("FAIL %s[%0d] got cur=%h valid=%b slot=%0d irl=%b busy=%b halted=%b, required cur=%h valid=%b slot=%0d irl=%b busy=%b halted=%b",
                 tag, idx, bus.cur_oper, bus.oper_valid, bus.slot, bus.ir_load, bus.busy,
                 bus.halted, t.e_cur, t.e_valid, t.e_slot, t.e_irl, t.e_busy, t.e_halt);
      end
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];
  vec_t seq[$];

  initial begin
    //               rst  st   rdy  c1   c2   c3   c4   chk  cur  vld  slot irl  bsy  hlt
    tbl.push_back(v(1'b1,1'b0,1'b0,HLT, HLT, HLT, HLT, 1'b0,4'h0,1'b0,2'd0,1'b0,1'b0,1'b0));
    tbl.push_back(v(1'b0,1'b0,1'b0,HLT, HLT, HLT, HLT, 1'b1,4'h0,1'b0,2'd0,1'b0,1'b0,1'b0));
    tbl.push_back(v(1'b0,1'b1,1'b1,HLT, HLT, HLT, HLT, 1'b1,4'h0,1'b0,2'd0,1'b0,1'b0,1'b0));
    // boot fetch, then latch the ALU instruction
    tbl.push_back(v(1'b0,1'b0,1'b1,HLT, HLT, HLT, HLT, 1'b1,RI,  1'b1,2'd0,1'b1,1'b1,1'b0));
    tbl.push_back(v(1'b0,1'b0,1'b1,RR,  ALU, WR,  RI,  1'b1,4'h0,1'b0,2'd0,1'b0,1'b1,1'b0));
    tbl.push_back(v(1'b0,1'b0,1'b1,HLT, HLT, HLT, HLT, 1'b1,RR,  1'b1,2'd0,1'b0,1'b1,1'b0));
    tbl.push_back(v(1'b0,1'b0,1'b1,HLT, HLT, HLT, HLT, 1'b1,ALU, 1'b1,2'd1,1'b0,1'b1,1'b0));
    tbl.push_back(v(1'b0,1'b0,1'b1,HLT, HLT, HLT, HLT, 1'b1,WR,  1'b1,2'd2,1'b0,1'b1,1'b0));
    tbl.push_back(v(1'b0,1'b0,1'b1,HLT, HLT, HLT, HLT, 1'b1,RI,  1'b1,2'd3,1'b1,1'b1,1'b0));
    // latch second instruction; SLOT still shows 3 until the latch edge
    tbl.push_back(v(1'b0,1'b0,1'b1,NOP, ALU, WR,  WR,  1'b1,4'h0,1'b0,2'd3,1'b0,1'b1,1'b0));
    tbl.push_back(v(1'b0,1'b0,1'b1,HLT, HLT, HLT, HLT, 1'b1,NOP, 1'b1,2'd0,1'b0,1'b1,1'b0));
    // three-cycle stall at slot 1
    tbl.push_back(v(1'b0,1'b0,1'b0,HLT, HLT, HLT, HLT, 1'b1,ALU, 1'b1,2'd1,1'b0,1'b1,1'b0));
    tbl.push_back(v(1'b0,1'b0,1'b0,HLT, HLT, HLT, HLT, 1'b1,ALU, 1'b1,2'd1,1'b0,1'b1,1'b0));
    tbl.push_back(v(1'b0,1'b0,1'b0,HLT, HLT, HLT, HLT, 1'b1,ALU, 1'b1,2'd1,1'b0,1'b1,1'b0));
    tbl.push_back(v(1'b0,1'b0,1'b1,HLT, HLT, HLT, HLT, 1'b1,ALU, 1'b1,2'd1,1'b0,1'b1,1'b0));
    tbl.push_back(v(1'b0,1'b0,1'b1,HLT, HLT, HLT, HLT, 1'b1,WR,  1'b1,2'd2,1'b0,1'b1,1'b0));
    // slot 3 is WRITE_REG: forced fetch follows at SLOT=3 (START ignored there)
    tbl.push_back(v(1'b0,1'b0,1'b1,HLT, HLT, HLT, HLT, 1'b1,WR,  1'b1,2'd3,1'b0,1'b1,1'b0));
    tbl.push_back(v(1'b0,1'b1,1'b1,HLT, HLT, HLT, HLT, 1'b1,RI,  1'b1,2'd3,1'b1,1'b1,1'b0));
    // halt in slot 0
    tbl.push_back(v(1'b0,1'b0,1'b1,HLT, RR,  RR,  RR,  1'b1,4'h0,1'b0,2'd3,1'b0,1'b1,1'b0));
    tbl.push_back(v(1'b0,1'b0,1'b1,RR,  RR,  RR,  RR,  1'b1,HLT, 1'b0,2'd0,1'b0,1'b1,1'b0));
    tbl.push_back(v(1'b0,1'b1,1'b1,RR,  RR,  RR,  RR,  1'b1,4'h0,1'b0,2'd0,1'b0,1'b0,1'b1));
    tbl.push_back(v(1'b0,1'b0,1'b1,RI,  RI,  RI,  RI,  1'b1,4'h0,1'b0,2'd0,1'b0,1'b0,1'b1));
    tbl.push_back(v(1'b0,1'b1,1'b0,RI,  RI,  RI,  RI,  1'b1,4'h0,1'b0,2'd0,1'b0,1'b0,1'b1));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], "tbl", i);

    // Reset out of HALT, boot, then reset again while slot 2 is stalled
    seq.push_back(v(1'b1,1'b1,1'b0,HLT, HLT, HLT, HLT, 1'b1,4'h0,1'b0,2'd0,1'b0,1'b0,1'b1));
    seq.push_back(v(1'b0,1'b0,1'b0,HLT, HLT, HLT, HLT, 1'b1,4'h0,1'b0,2'd0,1'b0,1'b0,1'b0));
    seq.push_back(v(1'b0,1'b1,1'b1,HLT, HLT, HLT, HLT, 1'b1,4'h0,1'b0,2'd0,1'b0,1'b0,1'b0));
    seq.push_back(v(1'b0,1'b0,1'b1,HLT, HLT, HLT, HLT, 1'b1,RI,  1'b1,2'd0,1'b1,1'b1,1'b0));
    seq.push_back(v(1'b0,1'b0,1'b1,RR,  ALU, WR,  RI,  1'b1,4'h0,1'b0,2'd0,1'b0,1'b1,1'b0));
    seq.push_back(v(1'b0,1'b0,1'b1,HLT, HLT, HLT, HLT, 1'b1,RR,  1'b1,2'd0,1'b0,1'b1,1'b0));
    seq.push_back(v(1'b0,1'b0,1'b1,HLT, HLT, HLT, HLT, 1'b1,ALU, 1'b1,2'd1,1'b0,1'b1,1'b0));
    seq.push_back(v(1'b1,1'b1,1'b0,HLT, HLT, HLT, HLT, 1'b1,WR,  1'b1,2'd2,1'b0,1'b1,1'b0));
    seq.push_back(v(1'b0,1'b0,1'b1,HLT, HLT, HLT, HLT, 1'b1,4'h0,1'b0,2'd0,1'b0,1'b0,1'b0));
    seq.push_back(v(1'b0,1'b1,1'b1,HLT, HLT, HLT, HLT, 1'b1,4'h0,1'b0,2'd0,1'b0,1'b0,1'b0));
    seq.push_back(v(1'b0,1'b0,1'b1,HLT, HLT, HLT, HLT, 1'b1,RI,  1'b1,2'd0,1'b1,1'b1,1'b0));
    seq.push_back(v(1'b0,1'b0,1'b0,NOP, NOP, NOP, NOP, 1'b1,4'h0,1'b0,2'd0,1'b0,1'b1,1'b0));
    seq.push_back(v(1'b0,1'b0,1'b0,HLT, HLT, HLT, HLT, 1'b1,NOP, 1'b1,2'd0,1'b0,1'b1,1'b0));

    for (int i = 0; i < seq.size(); i++) apply(seq[i], "rst_seq", i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
